// File: rtl/alu_arbiter.sv
// Round-robin arbiter that lends one shared combinational ALU to NUM_REQ requesters
// and returns the registered result and flags to whoever was granted.
module alu_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [4*NUM_REQ-1:0]    req_op,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [31:0]             rsp_c,
  output logic                    rsp_zero,
  output logic                    rsp_lt,
  output logic                    rsp_slt,
  output logic [3:0]              alu_operation,
  output logic [31:0]             alu_a,
  output logic [31:0]             alu_b,
  input  logic [31:0]             alu_c,
  input  logic                    zero,
  input  logic                    less_than,
  input  logic                    signed_less_than
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic {IDLE, RESP} state_t;

  state_t              state, state_nxt;
  logic [ID_W-1:0]     last;
  logic [ID_W-1:0]     gnt_id;
  logic [ID_W-1:0]     idx;
  logic                gnt_any;
  logic [NUM_REQ-1:0]  gnt_oh;
  logic                start;
  logic                done;

  // Walk from furthest to nearest so the nearest valid after `last` wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ID_W'((int'(last) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = idx;
      end
    end
  end

  assign gnt_oh = gnt_any ? (NUM_REQ'(1) << gnt_id) : '0;

  always_comb begin
    state_nxt     = state;
    req_ready     = '0;
    alu_operation = 4'b0000;
    alu_a         = '0;
    alu_b         = '0;
    start         = 1'b0;
    done          = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_any) begin
          req_ready     = gnt_oh;
          alu_operation = req_op[4*gnt_id +: 4];
          alu_a         = req_a[32*gnt_id +: 32];
          alu_b         = req_b[32*gnt_id +: 32];
          start         = 1'b1;
          state_nxt     = RESP;
        end
      end
      RESP: begin
        // Only the owner's rsp_ready matters since rsp_valid is one-hot.
        if (|(rsp_valid & rsp_ready)) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ALU output capture stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      last      <= ID_W'(NUM_REQ - 1);
      rsp_c     <= '0;
      rsp_zero  <= 1'b0;
      rsp_lt    <= 1'b0;
      rsp_slt   <= 1'b0;
    end else if (start) begin
      rsp_valid <= gnt_oh;
      last      <= gnt_id;
      rsp_c     <= alu_c;
      rsp_zero  <= zero;
      rsp_lt    <= less_than;
      rsp_slt   <= signed_less_than;
    end else if (done) begin
      rsp_valid <= '0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a 2-requester instance with a vector table plus
// hand-written multi-cycle sequences, and a 3-requester instance for wrap-around.
module tb_alu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [7:0]  req_op;
  logic [63:0] req_a, req_b;
  logic [31:0] rsp_c, alu_a, alu_b, alu_c;
  logic        rsp_zero, rsp_lt, rsp_slt, zero, lt, slt;
  logic [3:0]  alu_operation;

  logic [2:0]  req_valid3, req_ready3, rsp_valid3, rsp_ready3;
  logic [11:0] req_op3;
  logic [95:0] req_a3, req_b3;
  logic [31:0] rsp_c3, alu_a3, alu_b3, alu_c3;
  logic        rsp_zero3, rsp_lt3, rsp_slt3, zero3, lt3, slt3;
  logic [3:0]  alu_operation3;

  // Reference ALU: 0 ADD, 1 SUB, 2 SLL, 3 SLTU, anything else XOR.
  function automatic logic [34:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] c;
    case (op)
      4'd0:    c = a + b;
      4'd1:    c = a - b;
      4'd2:    c = a << b[4:0];
      4'd3:    c = {31'b0, a < b};
      default: c = a ^ b;
    endcase
    return {c, c == 32'd0, a < b, $signed(a) < $signed(b)};
  endfunction

  assign {alu_c, zero, lt, slt}     = alu_model(alu_operation, alu_a, alu_b);
  assign {alu_c3, zero3, lt3, slt3} = alu_model(alu_operation3, alu_a3, alu_b3);

  alu_arbiter #(.NUM_REQ(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c),
    .rsp_zero(rsp_zero), .rsp_lt(rsp_lt), .rsp_slt(rsp_slt),
    .alu_operation(alu_operation), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .zero(zero), .less_than(lt), .signed_less_than(slt)
  );

  alu_arbiter #(.NUM_REQ(3)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_op(req_op3), .req_a(req_a3), .req_b(req_b3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_c(rsp_c3),
    .rsp_zero(rsp_zero3), .rsp_lt(rsp_lt3), .rsp_slt(rsp_slt3),
    .alu_operation(alu_operation3), .alu_a(alu_a3), .alu_b(alu_b3), .alu_c(alu_c3),
    .zero(zero3), .less_than(lt3), .signed_less_than(slt3)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, c;
    logic        z, lt, slt;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [1:0] oh;
    int r;

    vecs[0] = '{4'd0,  32'd5,          32'd7,          32'd12,         1'b0, 1'b1, 1'b1};
    vecs[1] = '{4'd1,  32'd9,          32'd9,          32'd0,          1'b1, 1'b0, 1'b0};
    vecs[2] = '{4'd3,  32'd1,          32'hFFFF_FFFF,  32'd1,          1'b0, 1'b1, 1'b0};
    vecs[3] = '{4'd2,  32'd1,          32'd33,         32'd2,          1'b0, 1'b1, 1'b1};
    vecs[4] = '{4'd1,  32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0, 1'b1, 1'b1};
    vecs[5] = '{4'hF,  32'hF0F0_0000,  32'h0F0F_0000,  32'hFFFF_0000,  1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    req_valid = '0; rsp_ready = '0; req_op = '0; req_a = '0; req_b = '0;
    req_valid3 = '0; rsp_ready3 = '0; req_op3 = '0; req_a3 = '0; req_b3 = '0;
    #3;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_c", 64'(rsp_c), 64'd0);
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    chk("reset_alu_op", 64'(alu_operation), 64'd0);
    chk("reset_rsp_valid3", 64'(rsp_valid3), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single-requester vectors, alternating requester
    for (int i = 0; i < 6; i++) begin
      r = i % 2;
      oh = '0;
      oh[r] = 1'b1;
      @(negedge clk);
      req_op[4*r +: 4] = vecs[i].op;
      req_a[32*r +: 32] = vecs[i].a;
      req_b[32*r +: 32] = vecs[i].b;
      req_valid = oh;
      rsp_ready = '0;
      #1;
      chk("vec_req_ready", 64'(req_ready), 64'(oh));
      chk("vec_alu_op", 64'(alu_operation), 64'(vecs[i].op));
      chk("vec_alu_a", 64'(alu_a), 64'(vecs[i].a));
      @(posedge clk); #1;
      req_valid = '0;
      chk("vec_rsp_valid", 64'(rsp_valid), 64'(oh));
      chk("vec_rsp_c", 64'(rsp_c), 64'(vecs[i].c));
      chk("vec_rsp_zero", 64'(rsp_zero), 64'(vecs[i].z));
      chk("vec_rsp_lt", 64'(rsp_lt), 64'(vecs[i].lt));
      chk("vec_rsp_slt", 64'(rsp_slt), 64'(vecs[i].slt));
      chk("vec_resp_req_ready", 64'(req_ready), 64'd0);
      chk("vec_resp_alu_a", 64'(alu_a), 64'd0);
      rsp_ready = 2'b11;
      @(posedge clk); #1;
      chk("vec_rsp_drop", 64'(rsp_valid), 64'd0);
      rsp_ready = '0;
    end

    // Both requesters continuously valid: strict alternation starting at req0
    @(negedge clk);
    req_valid = 2'b11;
    req_op = {4'd1, 4'd0};
    req_a = {32'd9, 32'd5};
    req_b = {32'd9, 32'd7};
    rsp_ready = 2'b11;
    #1;
    for (int j = 0; j < 4; j++) begin
      oh = (j % 2 == 1) ? 2'b10 : 2'b01;
      chk("rr_req_ready", 64'(req_ready), 64'(oh));
      @(posedge clk); #1;
      chk("rr_rsp_valid", 64'(rsp_valid), 64'(oh));
      chk("rr_rsp_c", 64'(rsp_c), (j % 2 == 1) ? 64'd0 : 64'd12);
      chk("rr_rsp_zero", 64'(rsp_zero), 64'(j % 2));
      @(posedge clk); #1;
    end

    // req0 stalls its response; req1 waits, and req1's own rsp_ready is ignored
    rsp_ready = 2'b10;
    chk("stall_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("stall_rsp_c", 64'(rsp_c), 64'd12);
      chk("stall_req_ready0", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 2'b11;
    req_valid = 2'b10;
    @(posedge clk); #1;
    chk("after_stall_req_ready", 64'(req_ready), 64'd2);
    chk("after_stall_rsp_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
    chk("after_stall_rsp_owner", 64'(rsp_valid), 64'd2);
    chk("after_stall_rsp_zero", 64'(rsp_zero), 64'd1);

    // Reset while in RESP drops the pending result immediately
    rsp_ready = '0;
    #2 rst = 1'b1;
    #1;
    chk("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midreset_rsp_c", 64'(rsp_c), 64'd0);
    chk("midreset_rsp_zero", 64'(rsp_zero), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("postreset_grant", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    chk("postreset_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("postreset_rsp_c", 64'(rsp_c), 64'd12);
    rsp_ready = 2'b11;
    req_valid = '0;
    @(posedge clk); #1;

    // Three requesters: rr pointer wraps from 2 back to 0
    req_valid3 = 3'b100;
    req_op3[11:8] = 4'd0;
    req_a3[95:64] = 32'd2;
    req_b3[95:64] = 32'd3;
    #1;
    chk("n3_first_grant", 64'(req_ready3), 64'h4);
    @(posedge clk); #1;
    chk("n3_rsp_valid", 64'(rsp_valid3), 64'h4);
    chk("n3_rsp_c", 64'(rsp_c3), 64'd5);
    req_valid3 = 3'b101;
    req_op3[3:0] = 4'd0;
    req_a3[31:0] = 32'd1;
    req_b3[31:0] = 32'd1;
    rsp_ready3 = 3'b111;
    @(posedge clk); #1;
    chk("n3_wrap_grant", 64'(req_ready3), 64'h1);
    @(posedge clk); #1;
    chk("n3_wrap_rsp_valid", 64'(rsp_valid3), 64'h1);
    chk("n3_wrap_rsp_c", 64'(rsp_c3), 64'd2);
    @(posedge clk); #1;
    chk("n3_next_grant", 64'(req_ready3), 64'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
